// File: rtl/mag_cmp_bist.sv
// Exhaustive BIST sequencer for a 3-bit magnitude comparator: sweeps all 64 {a,b} pairs and counts bad responses.
// Define MAG_BIST_STOP_EN to end the sweep at the first mismatching vector.
module mag_cmp_bist #(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [2:0] a_out,
    output logic [2:0] b_out,
    input  logic       ya_in,
    input  logic       yb_in,
    input  logic       ye_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] err_cnt,
    output logic [5:0] first_fail
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRIVE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

`ifdef MAG_BIST_STOP_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    logic [2:0] state_reg, state_next;
    logic [5:0] idx_reg, idx_next;
    logic [5:0] vec_reg, vec_next;
    logic [1:0] wait_reg, wait_next;
    logic [6:0] err_reg, err_next;
    logic [5:0] ff_reg, ff_next;
    logic [2:0] exp_resp;
    logic       mismatch;

    // vec_reg is loaded on entry to DRIVE so the operands hold steady through CHECK
    always_comb begin
        exp_resp = {vec_reg[5:3] > vec_reg[2:0],
                    vec_reg[5:3] < vec_reg[2:0],
                    vec_reg[5:3] == vec_reg[2:0]};
        mismatch = ({ya_in, yb_in, ye_in} != exp_resp);
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        vec_next   = vec_reg;
        wait_next  = wait_reg;
        err_next   = err_reg;
        ff_next    = ff_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    idx_next   = 6'd0;
                    vec_next   = 6'd0;
                    err_next   = 7'd0;
                    ff_next    = 6'd0;
                    state_next = S_DRIVE;
                end
            end
            S_DRIVE: begin
                wait_next  = 2'd0;
                state_next = (LAT == 1) ? S_CHECK : S_WAIT;
            end
            S_WAIT: begin
                if (int'(wait_reg) >= LAT - 2) begin
                    state_next = S_CHECK;
                end else begin
                    wait_next = wait_reg + 2'd1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    err_next = err_reg + 7'd1;
                    if (err_reg == 7'd0) begin
                        ff_next = idx_reg;
                    end
                end
                if (idx_reg == 6'd63 || (STOP_ON_FAIL && mismatch)) begin
                    state_next = S_DONE;
                end else begin
                    idx_next   = idx_reg + 6'd1;
                    vec_next   = idx_reg + 6'd1;
                    state_next = S_DRIVE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            idx_reg   <= 6'd0;
            vec_reg   <= 6'd0;
            wait_reg  <= 2'd0;
            err_reg   <= 7'd0;
            ff_reg    <= 6'd0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            vec_reg   <= vec_next;
            wait_reg  <= wait_next;
            err_reg   <= err_next;
            ff_reg    <= ff_next;
        end
    end

    assign a_out      = vec_reg[5:3];
    assign b_out      = vec_reg[2:0];
    assign busy       = (state_reg == S_DRIVE) || (state_reg == S_WAIT) || (state_reg == S_CHECK);
    assign done       = (state_reg == S_DONE);
    assign pass       = done && (err_reg == 7'd0);
    assign err_cnt    = err_reg;
    assign first_fail = ff_reg;

endmodule

// File: doc/mag_cmp_bist.md
MAG_CMP_BIST -- requirements
Module: mag_cmp_bist

Interface
REQ-001: Parameter LAT, default 1, is the number of cycles from a driven vector to a valid comparator response; legal range 1..4.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: rst  input  1  synchronous, active-high reset.
REQ-004: start  input  1  single-cycle request to begin a sweep.
REQ-005: a_out  output  3  operand A driven to the 3-bit comparator under test.
REQ-006: b_out  output  3  operand B driven to the comparator under test.
REQ-007: ya_in  input  1  comparator response, A greater than B.
REQ-008: yb_in  input  1  comparator response, A less than B.
REQ-009: ye_in  input  1  comparator response, A equal to B.
REQ-010: busy  output  1  high while a sweep is in progress.
REQ-011: done  output  1  high from sweep completion until the next start or reset.
REQ-012: pass  output  1  high only when done=1 and err_cnt=0.
REQ-013: err_cnt  output  7  number of mismatching vectors in the current or last sweep (0..64).
REQ-014: first_fail  output  6  index {a,b} of the first mismatching vector; 0 if none.

Function
REQ-015: FSM states are IDLE, DRIVE, WAIT, CHECK and DONE; the encoding is implementation choice.
REQ-016: IDLE or DONE with start=1 shall clear err_cnt, first_fail and the vector index, then enter DRIVE.
REQ-017: start shall be ignored while busy=1.
REQ-018: The 6-bit vector index idx runs 0..63; a_out=idx[5:3], b_out=idx[2:0] (A outer, B inner).
REQ-019: DRIVE lasts 1 cycle and registers a_out/b_out from idx; WAIT lasts LAT-1 cycles (skipped if LAT=1); CHECK lasts 1 cycle; each vector therefore takes LAT+1 cycles.
REQ-020: a_out/b_out shall remain stable from DRIVE through CHECK of the same vector.
REQ-021: In CHECK the expected response is {ya,yb,ye} = {a>b, a<b, a==b} (unsigned); any bit difference is one mismatch.
REQ-022: On a mismatch, err_cnt increments by 1; if err_cnt was 0 before the increment, first_fail captures idx.
REQ-023: After CHECK of idx=63 (no wrap to 0), the FSM enters DONE; otherwise idx increments and the FSM returns to DRIVE.
REQ-024: A full sweep takes 64*(LAT+1) cycles from the first DRIVE cycle to DONE entry.
REQ-025: busy=1 in DRIVE, WAIT and CHECK only; done=1 in DONE only; the FSM holds DONE until start or rst.
REQ-026: err_cnt and first_fail stay valid in DONE and are cleared only by start or rst.

Reset
REQ-027: rst=1 at any clock edge, including mid-sweep, shall force IDLE; a_out, b_out, busy, done, pass, err_cnt and first_fail all become 0.
REQ-028: When rst and start are high in the same cycle, rst wins and start is discarded.

Configuration
REQ-029: With macro MAG_BIST_STOP_EN defined, the first mismatch ends the sweep: after that CHECK the FSM enters DONE with err_cnt=1 and first_fail=idx.
REQ-030: Without MAG_BIST_STOP_EN, all 64 vectors are always checked regardless of mismatches.

Verification
REQ-031: Correct comparator model, LAT=1, start pulse -> busy for 128 cycles, then done=1, pass=1, err_cnt=0, first_fail=0.
REQ-032: Model with ye stuck at 0, LAT=2 -> done after 192 cycles, err_cnt=8, first_fail=0, pass=0.
REQ-033: Model with ya/yb swapped, no macro -> err_cnt=56, first_fail=1 (a=0, b=1); with MAG_BIST_STOP_EN -> done after 2*(LAT+1) cycles, err_cnt=1, first_fail=1.
REQ-034: rst asserted during CHECK of idx=20 -> next cycle IDLE, all outputs 0; a following start restarts at idx=0.
REQ-035: start re-pulsed at vector 10 while busy -> ignored, sweep completes normally; start in DONE -> counters cleared and a new sweep begins.
